// File: rtl/spi_flash_xip_rd_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_flash_pkg
// Brief    : Shared types and constants for the SPI flash XIP read path.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        RSP  = 3'd4,
        GAP  = 3'd5
    } state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 32;
    localparam int XFER_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

endpackage

`default_nettype wire

// File: rtl/spi_flash_xip_rd_if.sv
//------------------------------------------------------------------------------
// Module   : spi_flash_xip_rd_if
// Brief    : Request/response bus between the XIP window and the flash reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface spi_flash_xip_rd_if;
    import spi_flash_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_BITS-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

`default_nettype wire

// File: rtl/spi_flash_xip_rd_sck_gen.sv
//------------------------------------------------------------------------------
// Module   : spi_sck_gen
// Brief    : SPI clock divider with single-cycle rise/fall strobes.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic enable,
    output logic      sck,
    output logic      rise,
    output logic      fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_tick;

    assign w_tick = enable && (r_cnt == c_cnt_last);

    // Counter restarts from zero whenever disabled so the first edge of a
    // transfer lands exactly CLK_DIV cycles after enable rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!enable) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sck  = r_sck;
    assign rise = w_tick && !r_sck;
    assign fall = w_tick &&  r_sck;

endmodule

`default_nettype wire

// File: rtl/spi_flash_xip_rd.sv
//------------------------------------------------------------------------------
// Module   : spi_flash_xip_rd
// Brief    : Single-word 03h READ SPI master behind the flash XIP window.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_flash_xip_rd
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  wire logic         clock,
    input  wire logic         reset,
    spi_flash_xip_rd_if.slave bus,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  wire logic         miso
);

    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [GAP_W-1:0] c_gap_last   = GAP_W'(2 * CLK_DIV - 1);
    localparam logic [5:0]       c_cmd_last   = 6'(CMD_BITS - 1);
    localparam logic [5:0]       c_addr_last  = 6'(CMD_BITS + ADDR_BITS - 1);
    localparam logic [5:0]       c_data_first = 6'(CMD_BITS + ADDR_BITS);
    localparam logic [5:0]       c_data_last  = 6'(XFER_BITS - 1);

    state_t                            r_state;
    state_t                            w_next;
    logic [5:0]                        r_bit_cnt;
    logic [CMD_BITS+ADDR_BITS-1:0]     r_tx;
    logic [DATA_BITS-1:0]              r_rx;
    logic                              r_mosi;
    logic [GAP_W-1:0]                  r_gap_cnt;
    logic                              w_shift_en;
    logic                              w_rise;
    logic                              w_fall;
    logic                              w_accept;
    logic                              w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^bus.req_addr[1:0];

    assign w_shift_en = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (w_shift_en),
        .sck    (sck),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = CMD;
                end
            end
            CMD:  if (w_fall && (r_bit_cnt == c_cmd_last))  w_next = ADDR;
            ADDR: if (w_fall && (r_bit_cnt == c_addr_last)) w_next = DATA;
            DATA: if (w_fall && (r_bit_cnt == c_data_last)) w_next = RSP;
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = GAP;
            end
            GAP:  if (r_gap_cnt == c_gap_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The command/address word shifts out MSB first; zeros fill in behind it,
    // so mosi naturally reads 0 for the whole data phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_mosi    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_tx      <= {FLASH_CMD_READ, bus.req_addr[23:2], 2'b00};
                r_mosi    <= FLASH_CMD_READ[7];
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                r_tx      <= {r_tx[30:0], 1'b0};
                r_mosi    <= r_tx[30];
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if (w_rise && (r_bit_cnt >= c_data_first)) begin
                r_rx <= {r_rx[30:0], miso};
            end

            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign ss           = !w_shift_en;
    assign mosi         = r_mosi;
    assign bus.rsp_data = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_xip_rd.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_flash_xip_rd
// Brief    : Self-checking bench with a behavioural 03h flash and a scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_flash_xip_rd;

    localparam int DIV = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sck;
    logic ss;
    logic mosi;
    logic miso = 1'b0;

    spi_flash_xip_rd_if bus();

    spi_flash_xip_rd #(
        .CLK_DIV (DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .sck   (sck),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural flash: shifts in command/address on sck rise, drives data on sck fall.
    logic [7:0]  mem [0:1023];
    int          fl_cnt    = 0;
    int          fl_pulses = 0;
    logic [31:0] fl_sh     = '0;
    logic [7:0]  fl_cmd    = '0;
    logic [23:0] fl_addr   = '0;

    always @(posedge sck or posedge ss) begin
        if (ss) begin
            if (fl_cnt != 0) fl_pulses <= fl_cnt;
            fl_cnt <= 0;
        end else begin
            fl_sh <= {fl_sh[30:0], mosi};
            if (fl_cnt == 31) begin
                fl_cmd  <= fl_sh[30:23];
                fl_addr <= {fl_sh[22:0], mosi};
            end
            fl_cnt <= fl_cnt + 1;
        end
    end

    always @(negedge sck or posedge ss) begin : p_miso
        int         idx;
        logic [7:0] b;
        if (ss) begin
            miso <= 1'b0;
        end else if (fl_cnt >= 32) begin
            idx  = fl_cnt - 32;
            b    = mem[(int'(fl_addr[9:0]) + idx / 8) % 1024];
            miso <= b[7 - (idx % 8)];
        end
    end

    // Monitors sample on the falling clock edge; stimulus moves 1ns after the rising edge.
    int          cyc = 0;
    int          acc_cnt = 0;
    int          last_acc_edge = 0;
    int          n_rsp = 0;
    int          last_hs_edge = 0;
    int          last_lat = 0;
    int          bad_sck = 0;
    int          bad_mosi = 0;
    logic [31:0] last_rsp = '0;
    logic        prev_rv = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        prev_sck = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : p_mon
        int a;
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) begin
                a = {22'd0, bus.req_addr[9:2], 2'b00};
                exp_q.push_back({mem[a+3], mem[a+2], mem[a+1], mem[a]});
                acc_cnt++;
                last_acc_edge = cyc + 1;
            end
            if (bus.rsp_valid && !prev_rv) last_lat = cyc - last_acc_edge + 1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                last_hs_edge = cyc + 1;
                last_rsp     = bus.rsp_data;
                if (exp_q.size() == 0) check("sb_unexpected_rsp", 32'(exp_q.size()), 32'd1);
                else                   check("sb_rsp_data", bus.rsp_data, exp_q.pop_front());
            end
            if (sck && ss) bad_sck++;
            if ((mosi !== prev_mosi) && prev_sck && sck) bad_mosi++;
            prev_rv   = bus.rsp_valid;
            prev_mosi = mosi;
            prev_sck  = sck;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_acc(input int prev, input string tag);
        int k = 0;
        while (acc_cnt <= prev && k < 2000) begin tick(1); k++; end
        check(tag, 32'(acc_cnt > prev), 32'd1);
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int k = 0;
        while (n_rsp < target && k < 3000) begin tick(1); k++; end
        check(tag, 32'(n_rsp >= target), 32'd1);
    endtask

    task automatic read_one(input logic [23:0] addr, input string tag);
        int p = acc_cnt;
        int r = n_rsp;
        bus.req_addr  = addr;
        bus.req_valid = 1'b1;
        wait_acc(p, {tag, "_accept"});
        bus.req_valid = 1'b0;
        wait_rsp(r + 1, {tag, "_rsp"});
    endtask

    initial begin
        int p;
        int r;
        int e1;
        int k;
        int bp_bad;
        int rdy_bad;
        logic [31:0] d0;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 1);
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        mem[0]   = 8'hA1; mem[1]   = 8'hB2; mem[2]   = 8'hC3; mem[3]   = 8'hD4;
        mem[4]   = 8'h5E; mem[5]   = 8'h6F; mem[6]   = 8'h70; mem[7]   = 8'h81;

        tick(3);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ss",        ss,            1);
        check("rst_sck",       sck,           0);
        check("rst_mosi",      mosi,          0);
        check("rst_rsp_data",  bus.rsp_data,  0);
        reset = 1'b0;
        tick(2);

        // Basic read plus command/address decode, pulse count and latency
        read_one(24'h000100, "basic");
        check("basic_data",    last_rsp,  32'h44332211);
        check("basic_cmd",     fl_cmd,    8'h03);
        check("basic_addr",    fl_addr,   24'h000100);
        check("basic_pulses",  fl_pulses, 64);
        check("basic_latency", last_lat,  128 * DIV + 1);

        read_one(24'h000103, "lowbits");
        check("lowbits_data", last_rsp, 32'h44332211);
        check("lowbits_addr", fl_addr,  24'h000100);

        // Backpressure, with a second request parked on the bus the whole time
        bus.rsp_ready = 1'b0;
        p = acc_cnt;
        bus.req_addr  = 24'h000000;
        bus.req_valid = 1'b1;
        wait_acc(p, "bp_accept");
        bus.req_addr  = 24'h000004;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 1000) begin tick(1); k++; end
        check("bp_rsp_valid", bus.rsp_valid, 1);
        d0 = bus.rsp_data;
        bp_bad  = 0;
        rdy_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0) bp_bad++;
            if (bus.req_ready !== 1'b0) rdy_bad++;
        end
        check("bp_held_data",  d0,      32'hD4C3B2A1);
        check("bp_stable",     bp_bad,  0);
        check("bp_not_ready",  rdy_bad, 0);
        check("bp_no_accept",  acc_cnt, p + 1);
        p = acc_cnt;
        r = n_rsp;
        bus.rsp_ready = 1'b1;
        wait_rsp(r + 1, "bp_handshake");
        wait_acc(p, "bp_next_accept");
        bus.req_valid = 1'b0;
        check("bp_gap_edges", last_acc_edge - last_hs_edge, 2 * DIV + 1);
        wait_rsp(r + 2, "bp_next_rsp");
        check("bp_next_data", last_rsp, 32'h81706F5E);

        // Back-to-back with rsp_ready held high
        p = acc_cnt;
        r = n_rsp;
        bus.req_addr  = 24'h000000;
        bus.req_valid = 1'b1;
        wait_acc(p, "b2b_accept0");
        e1 = last_acc_edge;
        bus.req_addr = 24'h000004;
        wait_acc(p + 1, "b2b_accept1");
        bus.req_valid = 1'b0;
        check("b2b_spacing", last_acc_edge - e1, 130 * DIV + 2);
        wait_rsp(r + 2, "b2b_rsp");
        check("b2b_last_data", last_rsp, 32'h81706F5E);

        // Reset in the middle of the address phase
        p = acc_cnt;
        bus.req_addr  = 24'h000100;
        bus.req_valid = 1'b1;
        wait_acc(p, "mid_accept");
        bus.req_valid = 1'b0;
        k = 0;
        while (fl_cnt < 19 && k < 1000) begin tick(1); k++; end
        check("mid_reached_addr", 32'(fl_cnt >= 19), 1);
        reset = 1'b1;
        #1;
        check("mid_ss",        ss,            1);
        check("mid_sck",       sck,           0);
        check("mid_mosi",      mosi,          0);
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_rsp_data",  bus.rsp_data,  0);
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        r = n_rsp;
        tick(300);
        check("mid_no_partial", n_rsp, r);
        read_one(24'h000004, "mid_fresh");
        check("mid_fresh_data", last_rsp, 32'h81706F5E);

        check("proto_sck_while_ss_high", bad_sck,  0);
        check("proto_mosi_while_sck_hi", bad_mosi, 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
